jt12_logsin_pipe: RTL and testbench



---
 rtl/jt12_logsin_pipe.sv | 121 ++++++++++++
 tb/tb_jt12_logsin_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/jt12_logsin_pipe.sv
// jt12_logsin_pipe: three-stage log-sine decoder around the JT12 phase ROM.
//   S1 folds the 10-bit phase into a quarter-wave index and drives the ROM address.
//   S2 aligns the fine phase, sign and valid with the ROM's output register.
//   S3 adds the selected 4-bit delta nibble to the 12-bit ROM base.
// Optional feature macro: JT12_LOGSIN_SAT_EN
//   Defined:   a 13-bit sum that carries out is clamped to 12'hFFF.
//   Undefined: the sum wraps modulo 4096, so no compare/mux is built.
// The ROM itself lives outside this block and registers rom_ph on clk_en.

module jt12_logsin_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic [9:0]  phase,
  input  logic        phase_vld,
  output logic [4:0]  rom_addr,
  input  logic [45:0] rom_ph,
  output logic [11:0] logsin,
  output logic        sign,
  output logic        out_vld
);

  localparam int unsigned PL_W   = 8;
  localparam int unsigned FN_W   = 3;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned LS_W   = 12;
  localparam int unsigned SUM_W  = LS_W + 1;
  localparam int unsigned BASE_H = 45;
  localparam int unsigned BASE_L = 34;

  // S1 payload: folded quarter-wave position, sign and valid
  typedef struct packed {
    logic [PL_W-1:0] pl;
    logic            sg;
    logic            v;
  } s1_t;

  // S2 payload: fine phase travels alongside the ROM's output register
  typedef struct packed {
    logic [FN_W-1:0] fn;
    logic            sg;
    logic            v;
  } s2_t;

  s1_t              s1_q;
  s1_t              s1_d;
  s2_t              s2_q;
  s2_t              s2_d;

  logic [LS_W-1:0]  base_c;
  logic [NIB_W-1:0] nib_c;
  logic [SUM_W-1:0] sum_c;
  logic [LS_W-1:0]  logsin_d;
  logic             rsvd_unused;

  // Quarter-wave fold: the second quarter mirrors the first, so the peak entry repeats
  always_comb begin
    s1_d    = '0;
    s1_d.pl = phase[8] ? ~phase[PL_W-1:0] : phase[PL_W-1:0];
    s1_d.sg = phase[9];
    s1_d.v  = phase_vld;
  end

  // S1 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else if (clk_en) begin
      s1_q <= s1_d;
    end
  end

  // Coarse index straight from the S1 register; holds whenever clk_en is low
  assign rom_addr = s1_q.pl[PL_W-1:FN_W];

  // Fine phase, sign and valid move on in step with the ROM read
  always_comb begin
    s2_d    = '0;
    s2_d.fn = s1_q.pl[FN_W-1:0];
    s2_d.sg = s1_q.sg;
    s2_d.v  = s1_q.v;
  end

  // S2 register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_q <= '0;
    end else if (clk_en) begin
      s2_q <= s2_d;
    end
  end

  // Decode the ROM word: 12-bit base plus one of eight 4-bit deltas picked by the fine phase
  always_comb begin
    base_c = rom_ph[BASE_H:BASE_L];
    nib_c  = rom_ph[{1'b0, s2_q.fn, 2'b00} +: NIB_W];
    sum_c  = SUM_W'({1'b0, base_c}) + SUM_W'(nib_c);
`ifdef JT12_LOGSIN_SAT_EN
    logsin_d = sum_c[LS_W] ? {LS_W{1'b1}} : sum_c[LS_W-1:0];
`else
    logsin_d = sum_c[LS_W-1:0];
`endif
  end

  // Bits 33:32 of the ROM word are reserved; the carry is dropped in the wrapping build
  assign rsvd_unused = ^{rom_ph[33:32], sum_c[LS_W]};

  // S3 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      logsin  <= '0;
      sign    <= 1'b0;
      out_vld <= 1'b0;
    end else if (clk_en) begin
      logsin  <= logsin_d;
      sign    <= s2_q.sg;
      out_vld <= s2_q.v;
    end
  end

endmodule

// File: tb/tb_jt12_logsin_pipe.sv
// tb_jt12_logsin_pipe: scoreboard bench for the log-sine decoder.
// The driver pushes one expected record per enabled clock; the monitor pops one
// per enabled clock and compares out_vld, plus logsin/sign when valid.
`timescale 1ns/1ps

module tb_jt12_logsin_pipe;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic [9:0]  phase;
  logic        phase_vld;
  logic [4:0]  rom_addr;
  logic [45:0] rom_ph;
  logic [11:0] logsin;
  logic        sign;
  logic        out_vld;

`ifdef JT12_LOGSIN_SAT_EN
  localparam logic [11:0] SAT_EXP = 12'hFFF;
`else
  localparam logic [11:0] SAT_EXP = 12'h003;
`endif

  typedef struct packed {
    logic        vld;
    logic [11:0] ls;
    logic        sg;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks;
  int          n_fail;
  logic [45:0] rom_tbl [32];

  jt12_logsin_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_en    (clk_en),
    .phase     (phase),
    .phase_vld (phase_vld),
    .rom_addr  (rom_addr),
    .rom_ph    (rom_ph),
    .logsin    (logsin),
    .sign      (sign),
    .out_vld   (out_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase ROM model: registers the addressed word on enabled edges
  initial rom_ph = '0;
  always @(posedge clk) begin
    if (clk_en) rom_ph <= rom_tbl[rom_addr];
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; enabled clocks out of reset get a scoreboard record
  task automatic step(input logic en, input logic vld, input logic [9:0] ph,
                      input logic [11:0] ls, input logic sg);
    exp_t e;
    @(negedge clk);
    clk_en    = en;
    phase_vld = vld;
    phase     = ph;
    @(posedge clk);
    if (en && rst_n) begin
      e.vld = vld;
      e.ls  = ls;
      e.sg  = sg;
      sb_q.push_back(e);
    end
  endtask

  // Release reset with the enable low; the first two enabled outputs are reset-state bubbles
  task automatic release_rst();
    exp_t e;
    @(negedge clk);
    rst_n     = 1'b1;
    clk_en    = 1'b0;
    phase_vld = 1'b0;
    e = '0;
    sb_q.push_back(e);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 10'h000, 12'h000, 1'b0);
  endtask

  // Monitor: one scoreboard pop per enabled clock while out of reset
  always begin
    exp_t m;
    @(posedge clk);
    #1;
    if (rst_n && clk_en) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got out_vld=%b with no expected record at %0t", out_vld, $time);
      end else begin
        m = sb_q.pop_front();
        chk("out_vld", {15'd0, out_vld}, {15'd0, m.vld});
        if (m.vld) chk("logsin_sign", {3'd0, logsin, sign}, {3'd0, m.ls, m.sg});
      end
    end
  end

  // Stimulus
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    clk_en    = 1'b1;
    phase     = '0;
    phase_vld = 1'b0;
    for (int a = 0; a < 32; a++) rom_tbl[a] = '0;
    rom_tbl[0]  = {12'h010, 2'b01, 32'h8765_4321};
    rom_tbl[1]  = {12'h400, 2'b11, 32'h0000_7000};
    rom_tbl[2]  = {12'hFFE, 2'b00, 32'h0000_0005};
    rom_tbl[31] = {12'h123, 2'b00, 32'h3000_0A00};

    // Reset held with clocks running
    repeat (4) @(posedge clk);
    #1;
    chk("rst_logsin", {4'd0, logsin}, 16'h0000);
    chk("rst_sign", {15'd0, sign}, 16'h0000);
    chk("rst_out_vld", {15'd0, out_vld}, 16'h0000);
    chk("rst_rom_addr", {11'd0, rom_addr}, 16'h0000);
    release_rst();

    // Mirror, sign, reserved bits, saturation and peak duplication
    step(1'b1, 1'b1, 10'h105, 12'h12D, 1'b0);
    #1 chk("addr_mirror", {11'd0, rom_addr}, 16'h001F);
    step(1'b0, 1'b1, 10'h000, 12'h000, 1'b0);
    #1 chk("addr_hold", {11'd0, rom_addr}, 16'h001F);
    step(1'b1, 1'b1, 10'h20B, 12'h407, 1'b1);
    #1 chk("addr_plain", {11'd0, rom_addr}, 16'h0001);
    step(1'b1, 1'b1, 10'h010, SAT_EXP, 1'b0);
    step(1'b1, 1'b1, 10'h0FF, 12'h126, 1'b0);
    #1 chk("addr_0ff", {11'd0, rom_addr}, 16'h001F);
    step(1'b1, 1'b1, 10'h100, 12'h126, 1'b0);
    #1 chk("addr_100", {11'd0, rom_addr}, 16'h001F);
    step(1'b1, 1'b1, 10'h3FF, 12'h011, 1'b1);
    idle(3);

    // Streaming phases 0..7 with continuous enable
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 10'(i), 12'(12'h011 + i), 1'b0);
    idle(3);

    // Same stream with the enable high one clock in three
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 10'(i), 12'(12'h011 + i), 1'b0);
      step(1'b0, 1'b0, 10'h3FF, 12'h000, 1'b0);
      step(1'b0, 1'b1, 10'h2AA, 12'h000, 1'b0);
    end
    idle(3);

    // Alternating valid bubbles
    for (int i = 0; i < 6; i++) step(1'b1, (i % 2) == 0, 10'(i), 12'(12'h011 + i), 1'b0);
    idle(3);

    // Asynchronous reset with three samples in flight
    step(1'b1, 1'b1, 10'h000, 12'h011, 1'b0);
    step(1'b1, 1'b1, 10'h001, 12'h012, 1'b0);
    step(1'b1, 1'b1, 10'h002, 12'h013, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("async_out_vld", {15'd0, out_vld}, 16'h0000);
    chk("async_logsin", {4'd0, logsin}, 16'h0000);
    chk("async_rom_addr", {11'd0, rom_addr}, 16'h0000);
    repeat (2) @(posedge clk);
    release_rst();
    step(1'b1, 1'b1, 10'h003, 12'h014, 1'b0);
    step(1'b1, 1'b1, 10'h004, 12'h015, 1'b0);
    step(1'b1, 1'b1, 10'h005, 12'h016, 1'b0);
    idle(4);

    // Two idle records remain queued once the pipeline has drained
    #2 chk("sb_drain", 16'(sb_q.size()), 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
